// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-domain pointer/empty control for an async FIFO, with a first-word-fall-through output register.
// Latency: the head word reaches r_data one r_clk edge after empty deasserts; back-to-back pops sustain one word per cycle.
// Backpressure: a fetch occurs only when memory is non-empty and the output register is free or being popped; pops with r_valid=0 are ignored and set sticky underflow.
module fifo_rd_fwft #(
  parameter int P_SIZE   = 4,
  parameter int D_SIZE   = 8,
  parameter int AE_LEVEL = 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_inc,
  input  logic [P_SIZE-1:0] sync_wr_ptr,
  input  logic [D_SIZE-1:0] mem_rdata,
  output logic [P_SIZE-2:0] r_addr,
  output logic [P_SIZE-1:0] r_ptr,
  output logic [P_SIZE-1:0] gray_r_ptr,
  output logic [D_SIZE-1:0] r_data,
  output logic              r_valid,
  output logic              empty,
  output logic [P_SIZE-1:0] r_level,
  output logic              almost_empty,
  output logic              underflow
);

  localparam logic [P_SIZE-1:0] LP_AE = P_SIZE'(AE_LEVEL);

  logic              w_fetch;
  logic              w_valid_next;
  logic [P_SIZE-1:0] w_ptr_next;
  logic [P_SIZE-1:0] w_gray_next;
  logic [P_SIZE-1:0] w_wr_bin;
  logic [P_SIZE-1:0] w_level_next;

  // Gray pointer is updated together with the binary one, so this compare is never optimistic.
  assign empty        = (gray_r_ptr == sync_wr_ptr);
  // Pull the next word whenever the output register is free or is being consumed this cycle.
  assign w_fetch      = !empty && (!r_valid || r_inc);
  assign w_ptr_next   = w_fetch ? (r_ptr + P_SIZE'(1)) : r_ptr;
  assign w_gray_next  = w_ptr_next ^ (w_ptr_next >> 1);
  assign r_addr       = r_ptr[P_SIZE-2:0];
  assign almost_empty = (r_level <= LP_AE);

  // Output-register valid after this edge: a fetch refills it, an accepted pop alone drains it.
  always_comb begin
    w_valid_next = r_valid;
    if (w_fetch) begin
      w_valid_next = 1'b1;
    end else if (r_inc) begin
      w_valid_next = 1'b0;
    end
  end

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of all bits at or above i.
  always_comb begin
    w_wr_bin = '0;
    for (int i = 0; i < P_SIZE; i++) begin
      w_wr_bin[i] = ^(sync_wr_ptr >> i);
    end
  end

  // Occupancy counts words still in memory plus the one held in the output register.
  assign w_level_next = (w_wr_bin - w_ptr_next) + {{(P_SIZE-1){1'b0}}, w_valid_next};

  // Binary and Gray read pointers advance on every fetch.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_ptr      <= '0;
      gray_r_ptr <= '0;
    end else begin
      r_ptr      <= w_ptr_next;
      gray_r_ptr <= w_gray_next;
    end
  end

  // FWFT output register: capture the word at r_addr on fetch; keep stale data otherwise.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_data <= mem_rdata;
      end
      r_valid <= w_valid_next;
    end
  end

  // Registered occupancy and sticky underflow on a pop with nothing to consume.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_level   <= '0;
      underflow <= 1'b0;
    end else begin
      r_level <= w_level_next;
      if (r_inc && !r_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: directed table/sequence checks plus randomized traffic against a queue-based reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The bench plays the write side, writing memory only into slots not yet fetched.
module tb_fifo_rd_fwft;
  localparam int P = 4;
  localparam int D = 8;

  logic         r_clk = 1'b0;
  logic         r_rst = 1'b1;
  logic         r_inc = 1'b0;
  logic [P-1:0] sync_wr_ptr = '0;
  logic [D-1:0] mem_rdata;
  logic [P-2:0] r_addr;
  logic [P-1:0] r_ptr;
  logic [P-1:0] gray_r_ptr;
  logic [D-1:0] r_data;
  logic         r_valid;
  logic         empty;
  logic [P-1:0] r_level;
  logic         almost_empty;
  logic         underflow;

  logic [D-1:0] mem [8];
  int total = 0;
  int bad   = 0;

  assign mem_rdata = mem[r_addr];

  always #5 r_clk = ~r_clk;

  fifo_rd_fwft #(.P_SIZE(P), .D_SIZE(D), .AE_LEVEL(1)) dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .r_inc        (r_inc),
    .sync_wr_ptr  (sync_wr_ptr),
    .mem_rdata    (mem_rdata),
    .r_addr       (r_addr),
    .r_ptr        (r_ptr),
    .gray_r_ptr   (gray_r_ptr),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .empty        (empty),
    .r_level      (r_level),
    .almost_empty (almost_empty),
    .underflow    (underflow)
  );

  function automatic logic [3:0] gray(input int x);
    logic [3:0] b;
    b = x[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  typedef struct {
    logic       inc;
    logic       v;
    logic [7:0] d;
    logic [3:0] p;
    logic       e;
    logic [3:0] lvl;
  } vec_t;

  vec_t tbl[9];

  // Reference model state for random traffic
  logic [7:0] q[$];
  logic       m_hv;
  logic [7:0] m_hd;
  logic       m_uf;
  int         wr_cnt;
  int         rd_cnt;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // ---- Reset state ----
    #12;
    chk("rst.r_ptr", r_ptr, 0);
    chk("rst.gray", gray_r_ptr, 0);
    chk("rst.r_valid", r_valid, 0);
    chk("rst.r_data", r_data, 0);
    chk("rst.empty", empty, 1);
    chk("rst.r_level", r_level, 0);
    chk("rst.almost_empty", almost_empty, 1);
    chk("rst.underflow", underflow, 0);
    r_rst = 1'b0;

    // ---- First word fall-through ----
    mem[0] = 8'hA5;
    sync_wr_ptr = 4'b0001;
    #1;
    chk("fwft.empty_pre", empty, 0);
    step();
    chk("fwft.r_valid", r_valid, 1);
    chk("fwft.r_data", r_data, 8'hA5);
    chk("fwft.r_ptr", r_ptr, 1);
    chk("fwft.gray", gray_r_ptr, 4'b0001);
    chk("fwft.empty", empty, 1);
    step();
    chk("fwft.r_level", r_level, 1);
    chk("fwft.r_valid_hold", r_valid, 1);
    chk("fwft.almost_empty", almost_empty, 1);
    r_inc = 1'b1;
    step();
    r_inc = 1'b0;
    chk("pop.r_valid", r_valid, 0);
    chk("pop.r_data_stale", r_data, 8'hA5);
    chk("pop.r_ptr", r_ptr, 1);
    chk("pop.r_level", r_level, 0);
    chk("pop.underflow", underflow, 0);

    // ---- Streaming full drain (table-driven) ----
    r_rst = 1'b1;
    sync_wr_ptr = 4'b0000;
    #2;
    r_rst = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 8; k++) begin
      tbl[k].inc = (k != 0);
      tbl[k].v   = 1'b1;
      tbl[k].d   = 8'h10 + 8'(k);
      tbl[k].p   = 4'(k + 1);
      tbl[k].e   = (k == 7);
      tbl[k].lvl = 4'(8 - k);
    end
    tbl[8].inc = 1'b1; tbl[8].v = 1'b0; tbl[8].d = 8'h17;
    tbl[8].p = 4'd8; tbl[8].e = 1'b1; tbl[8].lvl = 4'd0;
    sync_wr_ptr = 4'b1100;
    for (int k = 0; k < 9; k++) begin
      r_inc = tbl[k].inc;
      step();
      chk($sformatf("drain[%0d].r_valid", k), r_valid, tbl[k].v);
      chk($sformatf("drain[%0d].r_data", k), r_data, tbl[k].d);
      chk($sformatf("drain[%0d].r_ptr", k), r_ptr, tbl[k].p);
      chk($sformatf("drain[%0d].gray", k), gray_r_ptr, gray(int'(tbl[k].p)));
      chk($sformatf("drain[%0d].r_addr", k), r_addr, tbl[k].p[2:0]);
      chk($sformatf("drain[%0d].empty", k), empty, tbl[k].e);
      chk($sformatf("drain[%0d].r_level", k), r_level, tbl[k].lvl);
    end
    r_inc = 1'b0;
    chk("drain.gray_end", gray_r_ptr, 4'b1100);
    chk("drain.underflow", underflow, 0);

    // ---- Advance to r_ptr=1111, then wrap ----
    for (int i = 0; i < 7; i++) mem[i] = 8'h48 + 8'(i);
    sync_wr_ptr = gray(15);
    for (int j = 0; j < 7; j++) begin
      r_inc = (j != 0);
      step();
      chk($sformatf("adv[%0d].r_data", j), r_data, 8'h48 + 8'(j));
      chk($sformatf("adv[%0d].r_ptr", j), r_ptr, 9 + j);
    end
    chk("adv.r_ptr_end", r_ptr, 4'b1111);
    chk("adv.gray_end", gray_r_ptr, 4'b1000);
    chk("adv.empty", empty, 1);
    chk("adv.r_valid", r_valid, 1);
    chk("wrap.r_addr_pre", r_addr, 3'd7);
    mem[7] = 8'hC7;
    sync_wr_ptr = 4'b0000;
    r_inc = 1'b1;
    step();
    chk("wrap.r_data", r_data, 8'hC7);
    chk("wrap.r_ptr", r_ptr, 0);
    chk("wrap.gray", gray_r_ptr, 0);
    chk("wrap.empty", empty, 1);
    chk("wrap.r_valid", r_valid, 1);
    chk("wrap.r_level", r_level, 1);

    // ---- Underflow and hold ----
    step();
    chk("uf.pop_last_valid", r_valid, 0);
    chk("uf.before", underflow, 0);
    step();
    r_inc = 1'b0;
    chk("uf.set", underflow, 1);
    chk("uf.r_ptr_hold", r_ptr, 0);
    chk("uf.r_data_hold", r_data, 8'hC7);
    chk("uf.r_valid", r_valid, 0);
    for (int j = 0; j < 3; j++) step();
    chk("uf.sticky", underflow, 1);

    // ---- Reset mid-operation ----
    for (int i = 0; i < 7; i++) mem[i] = 8'h60 + 8'(i);
    sync_wr_ptr = gray(7);
    step();
    r_inc = 1'b1;
    for (int j = 0; j < 4; j++) step();
    chk("mid.r_ptr", r_ptr, 4'b0101);
    chk("mid.r_valid", r_valid, 1);
    chk("mid.r_level", r_level, 3);
    chk("mid.r_data", r_data, 8'h64);
    #2;
    r_rst = 1'b1;
    #1;
    chk("mid_rst.r_ptr", r_ptr, 0);
    chk("mid_rst.gray", gray_r_ptr, 0);
    chk("mid_rst.r_data", r_data, 0);
    chk("mid_rst.r_valid", r_valid, 0);
    chk("mid_rst.r_level", r_level, 0);
    chk("mid_rst.almost_empty", almost_empty, 1);
    chk("mid_rst.underflow", underflow, 0);
    chk("mid_rst.empty", empty, 0);
    step();
    chk("mid_rst.no_fetch_ptr", r_ptr, 0);
    chk("mid_rst.no_fetch_valid", r_valid, 0);
    r_inc = 1'b0;
    sync_wr_ptr = 4'b0000;
    step();
    r_rst = 1'b0;

    // ---- Randomized traffic vs. queue model ----
    q.delete();
    m_hv = 1'b0;
    m_hd = 8'h00;
    m_uf = 1'b0;
    wr_cnt = 0;
    rd_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit         exp_empty;
      bit         fetch;
      int         lvl;
      logic [7:0] w;
      // write side: at most one new word per cycle, never overwriting an unfetched slot
      if ((wr_cnt - rd_cnt) < 8 && ($urandom_range(2) != 0)) begin
        w = 8'($urandom);
        mem[wr_cnt % 8] = w;
        q.push_back(w);
        wr_cnt++;
        sync_wr_ptr = gray(wr_cnt);
      end
      // consumer: mostly legal pops, occasional pop with nothing valid
      if (m_hv) r_inc = ($urandom_range(99) < 65);
      else      r_inc = ($urandom_range(99) < 2);
      @(posedge r_clk);
      exp_empty = (q.size() == 0);
      fetch = !exp_empty && (!m_hv || r_inc);
      if (r_inc && !m_hv) m_uf = 1'b1;
      if (fetch) begin
        m_hd = q.pop_front();
        m_hv = 1'b1;
        rd_cnt++;
      end else if (r_inc && m_hv) begin
        m_hv = 1'b0;
      end
      lvl = q.size() + int'(m_hv);
      #1;
      chk("rnd.r_valid", r_valid, m_hv);
      chk("rnd.r_data", r_data, m_hd);
      chk("rnd.r_ptr", r_ptr, rd_cnt % 16);
      chk("rnd.gray", gray_r_ptr, gray(rd_cnt));
      chk("rnd.r_addr", r_addr, rd_cnt % 8);
      chk("rnd.empty", empty, (q.size() == 0));
      chk("rnd.r_level", r_level, lvl);
      chk("rnd.almost_empty", almost_empty, (lvl <= 1));
      chk("rnd.underflow", underflow, m_uf);
    end
    r_inc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
